axi_lite_master: RTL and testbench

Single-outstanding AXI4-Lite master that converts a simple command/response handshake into AXI4-Lite write and read transactions. It sits directly upstream of the AXI4-Lite slave stage and drives its address, data and response channels. It serves bench-less bring-up, CPU-less configuration sequencers and loopback tests. It also keeps a saturating error counter for non-OKAY responses.

---
 rtl/axi_lite_master.sv | 190 +++++++++++++++++++
 tb/tb_axi_lite_master.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI4-Lite master that maps a
// cmd/rsp handshake onto AXI4-Lite writes and reads, counting error responses.
module axi_lite_master #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDR_W-1:0]    cmd_addr,
    input  logic [DATA_W-1:0]    cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_write,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic [1:0]           rsp_resp,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [ADDR_W-1:0]    m_axi_awaddr,
    output logic                 m_axi_awvalid,
    input  logic                 m_axi_awready,
    output logic [DATA_W-1:0]    m_axi_wdata,
    output logic                 m_axi_wvalid,
    input  logic                 m_axi_wready,
    input  logic [1:0]           m_axi_bresp,
    input  logic                 m_axi_bvalid,
    output logic                 m_axi_bready,
    output logic [ADDR_W-1:0]    m_axi_araddr,
    output logic                 m_axi_arvalid,
    input  logic                 m_axi_arready,
    input  logic [DATA_W-1:0]    m_axi_rdata,
    input  logic [1:0]           m_axi_rresp,
    input  logic                 m_axi_rvalid,
    output logic                 m_axi_rready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_B,
        S_RD_GAP,
        S_RD_AR,
        S_RD_R,
        S_RSP
    } state_t;

    state_t               r_state;
    logic                 r_aw_done;
    logic                 r_w_done;
    logic [ADDR_W-1:0]    r_awaddr;
    logic                 r_awvalid;
    logic [DATA_W-1:0]    r_wdata;
    logic                 r_wvalid;
    logic                 r_bready;
    logic [ADDR_W-1:0]    r_araddr;
    logic                 r_arvalid;
    logic                 r_rready;
    logic                 r_rsp_valid;
    logic                 r_rsp_write;
    logic [DATA_W-1:0]    r_rsp_rdata;
    logic [1:0]           r_rsp_resp;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic w_aw_fire;
    logic w_w_fire;
    logic w_aw_ok;
    logic w_w_ok;
    logic w_err_sat;

    assign w_aw_fire = r_awvalid & m_axi_awready;
    assign w_w_fire  = r_wvalid & m_axi_wready;
    assign w_aw_ok   = r_aw_done | w_aw_fire;
    assign w_w_ok    = r_w_done | w_w_fire;
    assign w_err_sat = &r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_awaddr    <= '0;
            r_awvalid   <= 1'b0;
            r_wdata     <= '0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
            r_err_cnt   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (cmd_valid && cmd_write) begin
                        r_awaddr  <= cmd_addr;
                        r_wdata   <= cmd_wdata;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= S_WR;
                    end else if (cmd_valid) begin
                        r_araddr <= cmd_addr;
                        r_state  <= S_RD_GAP;
                    end
                end
                S_WR: begin
                    // AW and W complete independently; B is only
                    // accepted once both have landed.
                    if (w_aw_fire) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_fire) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_ok && w_w_ok) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WR_B;
                    end
                end
                S_WR_B: begin
                    if (m_axi_bvalid) begin
                        r_bready    <= 1'b0;
                        r_rsp_resp  <= m_axi_bresp;
                        r_rsp_write <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_valid <= 1'b1;
                        if (m_axi_bresp != 2'b00 && !w_err_sat)
                            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
                        r_state <= S_RSP;
                    end
                end
                S_RD_GAP: begin
                    // Guarantees a fresh arvalid rising edge per read.
                    r_arvalid <= 1'b1;
                    r_state   <= S_RD_AR;
                end
                S_RD_AR: begin
                    if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_R;
                    end
                end
                S_RD_R: begin
                    if (m_axi_rvalid) begin
                        r_rready    <= 1'b0;
                        r_rsp_resp  <= m_axi_rresp;
                        r_rsp_write <= 1'b0;
                        r_rsp_rdata <= m_axi_rdata;
                        r_rsp_valid <= 1'b1;
                        if (m_axi_rresp != 2'b00 && !w_err_sat)
                            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
                        r_state <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready     = (r_state == S_IDLE);
    assign rsp_valid     = r_rsp_valid;
    assign rsp_write     = r_rsp_write;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign err_cnt       = r_err_cnt;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: randomized self-checking bench with a behavioural
// AXI4-Lite slave and a memory/error-count reference model.
module tb_axi_lite_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int EW = 4;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [EW-1:0] err_cnt;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic          m_axi_awvalid, m_axi_awready;
    logic [DW-1:0] m_axi_wdata, m_axi_rdata;
    logic          m_axi_wvalid, m_axi_wready;
    logic [1:0]    m_axi_bresp, m_axi_rresp;
    logic          m_axi_bvalid, m_axi_bready;
    logic          m_axi_arvalid, m_axi_arready;
    logic          m_axi_rvalid, m_axi_rready;

    always #5 clk = ~clk;

    axi_lite_master #(.ADDR_W(AW), .DATA_W(DW), .ERR_CNT_W(EW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_cnt(err_cnt),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int vectors = 0;
    int miscompares = 0;

    // Slave configuration and state
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0] slv_bresp = 2'b00, slv_rresp = 2'b00;
    bit aw_got, w_got, ar_got, b_pend, r_pend;
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    logic [AW-1:0] cap_awaddr, cap_araddr;
    logic [DW-1:0] cap_wdata;
    logic [DW-1:0] slv_mem [logic [AW-1:0]];

    // Reference model state
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    int ref_err = 0;

    // Activity monitor
    int both_cyc = 0, aw_cyc = 0, w_cyc = 0, ar_rise = 0;
    logic prev_ar = 1'b0;

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : ~a;
    endfunction

    function automatic int sat_inc(input int c, input logic [1:0] r);
        return (r != 2'b00 && c < ERR_MAX) ? c + 1 : c;
    endfunction

    initial begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
        m_axi_bresp = 0; m_axi_arready = 0; m_axi_rvalid = 0;
        m_axi_rdata = 0; m_axi_rresp = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
                m_axi_arready = 0; m_axi_rvalid = 0;
                aw_got = 0; w_got = 0; ar_got = 0; b_pend = 0; r_pend = 0;
                aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
            end else begin
                if (b_pend) begin
                    m_axi_bvalid = 0; b_pend = 0;
                    aw_got = 0; w_got = 0; b_wait = 0;
                end else if (aw_got && w_got && !m_axi_bvalid) begin
                    if (b_wait >= b_dly) begin
                        m_axi_bvalid = 1; m_axi_bresp = slv_bresp;
                        slv_mem[cap_awaddr] = cap_wdata;
                    end else b_wait++;
                end
                b_pend = m_axi_bvalid && m_axi_bready;
                if (r_pend) begin
                    m_axi_rvalid = 0; r_pend = 0; ar_got = 0; r_wait = 0;
                end else if (ar_got && !m_axi_rvalid) begin
                    if (r_wait >= r_dly) begin
                        m_axi_rvalid = 1; m_axi_rresp = slv_rresp;
                        m_axi_rdata = slv_mem.exists(cap_araddr) ?
                                      slv_mem[cap_araddr] : ~cap_araddr;
                    end else r_wait++;
                end
                r_pend = m_axi_rvalid && m_axi_rready;
                m_axi_awready = 0;
                if (m_axi_awvalid && !aw_got) begin
                    if (aw_wait >= aw_dly) begin
                        m_axi_awready = 1; aw_got = 1; aw_wait = 0;
                        cap_awaddr = m_axi_awaddr;
                    end else aw_wait++;
                end
                m_axi_wready = 0;
                if (m_axi_wvalid && !w_got) begin
                    if (w_wait >= w_dly) begin
                        m_axi_wready = 1; w_got = 1; w_wait = 0;
                        cap_wdata = m_axi_wdata;
                    end else w_wait++;
                end
                m_axi_arready = 0;
                if (m_axi_arvalid && !ar_got) begin
                    if (ar_wait >= ar_dly) begin
                        m_axi_arready = 1; ar_got = 1; ar_wait = 0;
                        cap_araddr = m_axi_araddr;
                    end else ar_wait++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_axi_awvalid && m_axi_wvalid) both_cyc++;
            if (m_axi_awvalid) aw_cyc++;
            if (m_axi_wvalid) w_cyc++;
            if (m_axi_arvalid && !prev_ar) ar_rise++;
            prev_ar = m_axi_arvalid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Issues one command (called at a negedge) and returns the response
    // as seen at the first negedge with rsp_valid high.
    task automatic run_cmd(input bit w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, output bit ow,
                           output logic [DW-1:0] od, output logic [1:0] orsp,
                           output int lat, output bit tmo);
        int n;
        tmo = 0;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) tmo = 1;
        lat = 1;
        @(negedge clk);
        cmd_valid = 0;
        n = 0;
        while (!rsp_valid && n < 200) begin lat++; @(negedge clk); n++; end
        if (n >= 200) tmo = 1;
        ow = rsp_write; od = rsp_rdata; orsp = rsp_resp;
    endtask

    task automatic test_reset();
        rst = 1;
        @(negedge clk); @(negedge clk);
        vectors++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
             m_axi_rready, rsp_valid, rsp_write, cmd_ready} !== 8'b0000_0001) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 00000001",
                     {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                      m_axi_rready, rsp_valid, rsp_write, cmd_ready});
        end
        vectors++;
        if ({m_axi_awaddr, m_axi_wdata, m_axi_araddr, rsp_rdata, rsp_resp, err_cnt} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: aw=%h w=%h ar=%h rd=%h rsp=%b err=%0d want all 0",
                     m_axi_awaddr, m_axi_wdata, m_axi_araddr, rsp_rdata, rsp_resp, err_cnt);
        end
        rst = 0;
        ref_err = 0;
        @(negedge clk);
    endtask

    task automatic test_basic_write();
        bit ow, tmo; logic [DW-1:0] od; logic [1:0] orsp; int lat;
        int b0, a0, w0;
        b0 = both_cyc; a0 = aw_cyc; w0 = w_cyc;
        run_cmd(1, 32'h0000_0010, 32'hDEAD_BEEF, ow, od, orsp, lat, tmo);
        ref_mem[32'h10] = 32'hDEAD_BEEF;
        @(negedge clk);
        vectors++;
        if (tmo || ow !== 1'b1 || od !== 32'h0 || orsp !== 2'b00) begin
            miscompares++;
            $display("FAIL basic_write_rsp: tmo=%0b w=%b rd=%h resp=%b want w=1 rd=0 resp=00",
                     tmo, ow, od, orsp);
        end
        vectors++;
        if (both_cyc - b0 != 1 || aw_cyc - a0 != 1 || w_cyc - w0 != 1) begin
            miscompares++;
            $display("FAIL basic_write_valids: both=%0d aw=%0d w=%0d want 1/1/1",
                     both_cyc - b0, aw_cyc - a0, w_cyc - w0);
        end
        vectors++;
        if (cap_awaddr !== 32'h10 || cap_wdata !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL basic_write_payload: addr=%h data=%h want 00000010 deadbeef",
                     cap_awaddr, cap_wdata);
        end
        vectors++;
        if (lat != 3 || err_cnt !== EW'(ref_err)) begin
            miscompares++;
            $display("FAIL basic_write_lat: lat=%0d err=%0d want 3 and %0d", lat, err_cnt, ref_err);
        end
    endtask

    task automatic test_unaligned();
        int n;
        logic [2:0] exp_v;
        aw_dly = 0; w_dly = 3;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h14; cmd_wdata = 32'hDEAD_BEEF;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 0;
        for (int k = 1; k <= 5; k++) begin
            exp_v = {k == 1, k <= 4, k == 5};
            vectors++;
            if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== exp_v ||
                (m_axi_wvalid && m_axi_wdata !== 32'hDEAD_BEEF)) begin
                miscompares++;
                $display("FAIL unaligned_cyc%0d: aw/w/b=%b wdata=%h want %b deadbeef",
                         k, {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, m_axi_wdata, exp_v);
            end
            @(negedge clk);
        end
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        ref_mem[32'h14] = 32'hDEAD_BEEF;
        vectors++;
        if (n >= 50 || rsp_write !== 1'b1 || rsp_resp !== 2'b00) begin
            miscompares++;
            $display("FAIL unaligned_rsp: wait=%0d w=%b resp=%b want w=1 resp=00",
                     n, rsp_write, rsp_resp);
        end
        @(negedge clk);
        w_dly = 0;
    endtask

    task automatic test_back_to_back();
        bit ow, tmo; logic [DW-1:0] od; logic [1:0] orsp; int lat;
        logic [AW-1:0] addrs [2];
        int r0;
        addrs[0] = 32'h04; addrs[1] = 32'h08;
        slv_mem[32'h04] = 32'h1234_5678; ref_mem[32'h04] = 32'h1234_5678;
        slv_mem[32'h08] = 32'h9ABC_DEF0; ref_mem[32'h08] = 32'h9ABC_DEF0;
        r0 = ar_rise;
        for (int i = 0; i < 2; i++) begin
            run_cmd(0, addrs[i], 32'h0, ow, od, orsp, lat, tmo);
            vectors++;
            if (tmo || ow !== 1'b0 || od !== ref_read(addrs[i]) || orsp !== 2'b00 || lat != 4) begin
                miscompares++;
                $display("FAIL b2b_read%0d: tmo=%0b w=%b rd=%h resp=%b lat=%0d want w=0 rd=%h resp=00 lat=4",
                         i, tmo, ow, od, orsp, lat, ref_read(addrs[i]));
            end
        end
        @(negedge clk);
        vectors++;
        if (ar_rise - r0 != 2) begin
            miscompares++;
            $display("FAIL b2b_ar_edges: got %0d want 2", ar_rise - r0);
        end
    endtask

    task automatic test_errors();
        bit ow, tmo; logic [DW-1:0] od; logic [1:0] orsp; int lat;
        slv_rresp = 2'b10;
        run_cmd(0, 32'h20, 32'h0, ow, od, orsp, lat, tmo);
        ref_err = sat_inc(ref_err, 2'b10);
        @(negedge clk);
        vectors++;
        if (tmo || orsp !== 2'b10 || ow !== 1'b0 || err_cnt !== EW'(ref_err)) begin
            miscompares++;
            $display("FAIL err_read: resp=%b w=%b err=%0d want 10 0 %0d", orsp, ow, err_cnt, ref_err);
        end
        slv_rresp = 2'b00; slv_bresp = 2'b11;
        run_cmd(1, 32'h24, 32'h5555_AAAA, ow, od, orsp, lat, tmo);
        ref_mem[32'h24] = 32'h5555_AAAA;
        ref_err = sat_inc(ref_err, 2'b11);
        @(negedge clk);
        vectors++;
        if (tmo || orsp !== 2'b11 || ow !== 1'b1 || err_cnt !== 2) begin
            miscompares++;
            $display("FAIL err_write: resp=%b w=%b err=%0d want 11 1 2", orsp, ow, err_cnt);
        end
        slv_bresp = 2'b00;
    endtask

    task automatic test_saturate();
        bit ow, tmo; logic [DW-1:0] od; logic [1:0] orsp; int lat;
        slv_bresp = 2'b10;
        for (int i = 0; i < ERR_MAX + 5; i++) begin
            run_cmd(1, 32'h30, 32'(i), ow, od, orsp, lat, tmo);
            ref_mem[32'h30] = 32'(i);
            ref_err = sat_inc(ref_err, 2'b10);
            @(negedge clk);
            vectors++;
            if (tmo || err_cnt !== EW'(ref_err)) begin
                miscompares++;
                $display("FAIL saturate_%0d: err=%0d want %0d", i, err_cnt, ref_err);
            end
        end
        vectors++;
        if (err_cnt !== {EW{1'b1}}) begin
            miscompares++;
            $display("FAIL saturate_final: err=%0d want %0d", err_cnt, ERR_MAX);
        end
        slv_bresp = 2'b00;
    endtask

    task automatic test_stall();
        bit ow, tmo; logic [DW-1:0] od; logic [1:0] orsp; int lat;
        logic [DW-1:0] exp_d;
        rsp_ready = 0;
        run_cmd(0, 32'h04, 32'h0, ow, od, orsp, lat, tmo);
        exp_d = ref_read(32'h04);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h40; cmd_wdata = 32'hCAFE_F00D;
        for (int k = 0; k < 10; k++) begin
            vectors++;
            if (tmo || rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_rdata !== exp_d ||
                rsp_resp !== 2'b00 || cmd_ready !== 1'b0 || m_axi_awvalid !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_cyc%0d: v=%b w=%b rd=%h resp=%b cr=%b awv=%b want 1 0 %h 00 0 0",
                         k, rsp_valid, rsp_write, rsp_rdata, rsp_resp, cmd_ready, m_axi_awvalid, exp_d);
            end
            @(negedge clk);
        end
        cmd_valid = 0;
        rsp_ready = 1;
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_rdata !== exp_d ||
            m_axi_awvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_release: v=%b cr=%b rd=%h awv=%b want 0 1 %h 0",
                     rsp_valid, cmd_ready, rsp_rdata, m_axi_awvalid, exp_d);
        end
    endtask

    task automatic test_random();
        bit ow, tmo; logic [DW-1:0] od; logic [1:0] orsp; int lat;
        bit w; logic [AW-1:0] a; logic [DW-1:0] d; logic [1:0] r;
        logic [DW-1:0] exp_d;
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            a = 32'h100 + 32'(4 * $urandom_range(0, 7));
            d = $urandom;
            r = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            b_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
            r_dly = $urandom_range(0, 3);
            slv_bresp = r; slv_rresp = r;
            exp_d = w ? 32'h0 : ref_read(a);
            run_cmd(w, a, d, ow, od, orsp, lat, tmo);
            if (w) ref_mem[a] = d;
            ref_err = sat_inc(ref_err, r);
            @(negedge clk);
            vectors++;
            if (tmo || ow !== w || od !== exp_d || orsp !== r || err_cnt !== EW'(ref_err)) begin
                miscompares++;
                $display("FAIL random_%0d: tmo=%0b w=%b rd=%h resp=%b err=%0d want w=%b rd=%h resp=%b err=%0d",
                         i, tmo, ow, od, orsp, err_cnt, w, exp_d, r, ref_err);
            end
        end
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
        slv_bresp = 2'b00; slv_rresp = 2'b00;
    endtask

    task automatic test_reset_wr_b();
        bit ow, tmo; logic [DW-1:0] od; logic [1:0] orsp; int lat;
        int n, seen;
        b_dly = 6;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h50; cmd_wdata = 32'h0BAD_0BAD;
        n = 0;
        while (!m_axi_bready && n < 30) begin
            @(negedge clk); n++;
            if (!cmd_ready) cmd_valid = 0;
        end
        cmd_valid = 0;
        vectors++;
        if (n >= 30) begin
            miscompares++;
            $display("FAIL rst_wrb_reach: bready not seen within %0d cycles", n);
        end
        rst = 1;
        @(negedge clk);
        vectors++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
             m_axi_rready, rsp_valid, cmd_ready} !== 7'b000_0001 || err_cnt !== '0) begin
            miscompares++;
            $display("FAIL rst_wrb_state: ctrl=%b err=%0d want 0000001 0",
                     {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                      m_axi_rready, rsp_valid, cmd_ready}, err_cnt);
        end
        @(negedge clk);
        rst = 0;
        b_dly = 0;
        ref_err = 0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (rsp_valid || m_axi_bready) seen++;
            @(negedge clk);
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL rst_wrb_quiet: %0d cycles with rsp_valid/bready, want 0", seen);
        end
        run_cmd(0, 32'h50, 32'h0, ow, od, orsp, lat, tmo);
        @(negedge clk);
        vectors++;
        if (tmo || od !== ref_read(32'h50) || orsp !== 2'b00 || err_cnt !== '0) begin
            miscompares++;
            $display("FAIL rst_wrb_recover: rd=%h resp=%b err=%0d want %h 00 0",
                     od, orsp, err_cnt, ref_read(32'h50));
        end
    endtask

    initial begin
        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
        rsp_ready = 1;
        test_reset();
        test_basic_write();
        test_unaligned();
        test_back_to_back();
        test_errors();
        test_saturate();
        test_stall();
        test_random();
        test_reset_wr_b();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
